dbg_disp_ctrl: RTL and testbench
================================

Name: dbg_disp_ctrl

Overview:
Parametrised debug display controller for the single-cycle CPU board. It steps a read address through one of NUM_SRC debug channels (e.g. LED pattern ROM, register file, ALU taps, data memory) and captures the selected word. It then time-multiplexes that word as hex onto the 8-digit 7-segment display. Step source is auto (divided clock) or manual (debounced-by-sync pulse), with hold, per-channel wrap length and a wrap flag.

Parameters:
NUM_SRC, 4, number of debug channels (>=2)
SEL_W, 2, width of src_sel; 2**SEL_W >= NUM_SRC
ADDR_W, 6, read address width
DATA_W, 32, channel word width (fixed 32 for 8 hex digits)
DIV_W, 32, free-running divider width
DIV_FAST, 25, divider bit used for auto step when slow=0
DIV_SLOW, 27, divider bit used for auto step when slow=1
SCAN_BIT, 15, LSB of 3-bit digit scan index taken from divider

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
slow  in  1  auto step rate select (1 = DIV_SLOW)
run  in  1  1 = auto step, 0 = manual step
step_i  in  1  manual step request, asynchronous level
hold  in  1  freeze address and captured data
src_sel  in  SEL_W  channel select; values >= NUM_SRC read as 0
len_i  in  NUM_SRC*ADDR_W  per-channel length, channel k at [k*ADDR_W +: ADDR_W]; 0 means 2**ADDR_W
rd_data  in  NUM_SRC*DATA_W  per-channel read data, combinational from rd_addr
rd_addr  out  ADDR_W  current read address (registered)
data_q  out  DATA_W  captured display word
wrap_o  out  1  one-cycle pulse when rd_addr wraps to 0 by stepping
disp_seg_o  out  8  {dp,g,f,e,d,c,b,a}, active low, registered
disp_an_o  out  8  digit enables, active low one-hot, registered

Behaviour:
- Reset (async, rst=1): divider=0, rd_addr=0, data_q=0, wrap_o=0, sync/edge regs=0, sel_q=0, disp_seg_o=8'hFF, disp_an_o=8'hFF. All state resumes on the first clk edge after rst falls; reset mid-step discards the step.
- Divider: increments by 1 each cycle; wraps modulo 2**DIV_W.
- Auto tick (run=1): one-cycle pulse on each 0->1 transition of div[slow?DIV_SLOW:DIV_FAST], detected against the previous-cycle value of the same selected bit. Toggling slow may produce one extra tick; this is accepted.
- Manual tick (run=0): step_i passes a 2-FF synchronizer, then a rising-edge detect gives exactly one tick per press regardless of width. Auto ticks are ignored while run=0, and manual edges are ignored while run=1.
- Channel change: sel_q registers the effective sel each cycle. When effective sel != sel_q: rd_addr<=0 and wrap_o=0. This has priority over tick and hold.
- Step: on tick with hold=0 and no channel change, rd_addr <= (rd_addr+1 == L) ? 0 : rd_addr+1, where L = len_i of the selected channel, with 0 treated as 2**ADDR_W using an ADDR_W+1-bit compare. wrap_o=1 in that same cycle iff the wrap occurred.
- If rd_addr >= L after a len change, the next step still increments until modulo wrap at 2**ADDR_W (no forced clamp).
- Capture: when hold=0, data_q <= rd_data of the selected channel every cycle. data_q therefore reflects a new rd_addr one cycle after rd_addr changes. With hold=1, data_q is frozen.
- Scan: digit index d = div[SCAN_BIT+2:SCAN_BIT].
  - Next-cycle disp_an_o = ~(8'b1 << d).
  - Segment pattern = hex of data_q[4d+3:4d].
  - Encoding (active low, dp off): 0 C0, 1 F9, 2 A4, 3 B0, 4 99, 5 92, 6 82, 7 F8, 8 80, 9 90, A 88, b 83, C C6, d A1, E 86, F 8E.
  - dp (bit7) = 0 only on d=7 while hold=1.
  - Display latency is 1 cycle from divider/data_q.

Test Plan:
- Sim params DIV_FAST=2, DIV_SLOW=4, SCAN_BIT=0. Assert rst for 3 cycles mid-count -> seg=FF, an=FF, rd_addr=0, data_q=0. After release, the first scan digit shows 0 (an=FE, seg=C0).
- run=1, slow=0, src_sel=1, len ch1=5, ch1 data = 100+addr -> rd_addr 0,1,2,3,4,0 every 8 cycles. wrap_o single pulse on the 4->0 cycle. data_q=104 one cycle after rd_addr=4.
- run=0, step_i high for 7 cycles, then low, twice -> rd_addr increments exactly twice (0->1->2), with no auto ticks.
- rd_addr=3 on ch1, switch src_sel to 2 in the same cycle as a tick -> rd_addr=0 (tick dropped), data_q = ch2 word 0 one cycle later. src_sel=3 with NUM_SRC=3 -> channel 0.
- hold=1 for 40 cycles -> rd_addr and data_q constant, digit 7 seg bit7=0. Release -> stepping resumes from the same address.
- len ch0=0, rd_addr stepped from 62 -> 63 -> 0 with wrap_o pulse. data_q=32'h1234ABCD -> d=0: an=FE, seg=A1; d=3: an=F7, seg=88; d=7: an=7F, seg=F9.

Source files
------------

// File: rtl/dbg_disp_ctrl.sv
// Debug display controller: steps a read address through one of NUM_SRC debug
// channels, captures the selected word and scans it as hex on an 8-digit display.
module dbg_disp_ctrl #(
   parameter int NUM_SRC  = 4,
   parameter int SEL_W    = 2,
   parameter int ADDR_W   = 6,
   parameter int DATA_W   = 32,
   parameter int DIV_W    = 32,
   parameter int DIV_FAST = 25,
   parameter int DIV_SLOW = 27,
   parameter int SCAN_BIT = 15
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      slow,
   input  logic                      run,
   input  logic                      step_i,
   input  logic                      hold,
   input  logic [SEL_W-1:0]          src_sel,
   input  logic [NUM_SRC*ADDR_W-1:0] len_i,
   input  logic [NUM_SRC*DATA_W-1:0] rd_data,
   output logic [ADDR_W-1:0]         rd_addr,
   output logic [DATA_W-1:0]         data_q,
   output logic                      wrap_o,
   output logic [7:0]                disp_seg_o,
   output logic [7:0]                disp_an_o
);

   logic [DIV_W-1:0]  div;
   logic              auto_bit, auto_prev, auto_tick;
   logic              sync1, sync2, sync3, man_tick;
   logic              tick;
   logic [SEL_W-1:0]  sel_eff, sel_q;
   logic              sel_chg;
   logic [ADDR_W-1:0] len_sel;
   logic [DATA_W-1:0] data_sel;
   logic [ADDR_W:0]   lim, addr_inc;
   logic              wrap_hit;
   logic [ADDR_W-1:0] addr_nxt;
   logic [2:0]        dig;
   logic [3:0]        nib;
   logic [6:0]        hex_seg;

   // 7-segment hex patterns, active low, segments {g,f,e,d,c,b,a}
   function automatic logic [6:0] hex7(input logic [3:0] v);
      logic [6:0] s;
      case (v)
         4'h0: s = 7'h40;
         4'h1: s = 7'h79;
         4'h2: s = 7'h24;
         4'h3: s = 7'h30;
         4'h4: s = 7'h19;
         4'h5: s = 7'h12;
         4'h6: s = 7'h02;
         4'h7: s = 7'h78;
         4'h8: s = 7'h00;
         4'h9: s = 7'h10;
         4'hA: s = 7'h08;
         4'hB: s = 7'h03;
         4'hC: s = 7'h46;
         4'hD: s = 7'h21;
         4'hE: s = 7'h06;
         default: s = 7'h0E;
      endcase
      return s;
   endfunction

   // ---------------- step sources ----------------
   assign auto_bit  = slow ? div[DIV_SLOW] : div[DIV_FAST];
   assign auto_tick = auto_bit & ~auto_prev;
   assign man_tick  = sync2 & ~sync3;
   assign tick      = run ? auto_tick : man_tick;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div       <= '0;
         auto_prev <= 1'b0;
         sync1     <= 1'b0;
         sync2     <= 1'b0;
         sync3     <= 1'b0;
      end else begin
         div       <= div + 1'b1;
         auto_prev <= auto_bit;
         sync1     <= step_i;
         sync2     <= sync1;
         sync3     <= sync2;
      end
   end

   // ---------------- channel select ----------------
   assign sel_eff = (32'(src_sel) < NUM_SRC) ? src_sel : '0;
   assign sel_chg = (sel_eff != sel_q);

   always_comb begin
      len_sel  = '0;
      data_sel = '0;
      for (int k = 0; k < NUM_SRC; k++) begin
         if (sel_eff == SEL_W'(k)) begin
            len_sel  = len_i[k*ADDR_W +: ADDR_W];
            data_sel = rd_data[k*DATA_W +: DATA_W];
         end
      end
   end

   // Length 0 means the full 2**ADDR_W range; the extra bit also catches the
   // natural modulo wrap when rd_addr already sits beyond a shortened length.
   assign lim      = (len_sel == '0) ? {1'b1, {ADDR_W{1'b0}}} : {1'b0, len_sel};
   assign addr_inc = {1'b0, rd_addr} + 1'b1;
   assign wrap_hit = (addr_inc == lim) || addr_inc[ADDR_W];
   assign addr_nxt = wrap_hit ? '0 : addr_inc[ADDR_W-1:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sel_q   <= '0;
         rd_addr <= '0;
         wrap_o  <= 1'b0;
         data_q  <= '0;
      end else begin
         sel_q  <= sel_eff;
         wrap_o <= 1'b0;
         if (sel_chg) begin
            rd_addr <= '0;
         end else if (tick && !hold) begin
            rd_addr <= addr_nxt;
            wrap_o  <= wrap_hit;
         end
         if (!hold)
            data_q <= data_sel;
      end
   end

   // ---------------- display scan ----------------
   assign dig     = div[SCAN_BIT+2:SCAN_BIT];
   assign nib     = data_q[{dig, 2'b00} +: 4];
   assign hex_seg = hex7(nib);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         disp_seg_o <= 8'hFF;
         disp_an_o  <= 8'hFF;
      end else begin
         disp_an_o  <= ~(8'd1 << dig);
         // decimal point on the leftmost digit marks a frozen display
         disp_seg_o <= {~(hold && (dig == 3'd7)), hex_seg};
      end
   end

endmodule

// File: tb/tb_dbg_disp_ctrl.sv
// Randomized bench for dbg_disp_ctrl against a cycle-level behavioural model.
module tb_dbg_disp_ctrl;

   localparam int NS = 3;
   localparam int AW = 6;

   logic              clk = 1'b0;
   logic              rst, slow, run, step_i, hold;
   logic [1:0]        src_sel;
   logic [NS*AW-1:0]  len_i;
   logic [NS*32-1:0]  rd_data;
   logic [AW-1:0]     rd_addr;
   logic [31:0]       data_q;
   logic              wrap_o;
   logic [7:0]        disp_seg_o, disp_an_o;

   logic [AW-1:0]     lenv [NS];
   logic [31:0]       mem  [NS][64];

   int n_chk = 0;
   int n_fail = 0;

   dbg_disp_ctrl #(
      .NUM_SRC(NS), .SEL_W(2), .ADDR_W(AW), .DATA_W(32), .DIV_W(32),
      .DIV_FAST(2), .DIV_SLOW(4), .SCAN_BIT(0)
   ) dut (
      .clk(clk), .rst(rst), .slow(slow), .run(run), .step_i(step_i), .hold(hold),
      .src_sel(src_sel), .len_i(len_i), .rd_data(rd_data), .rd_addr(rd_addr),
      .data_q(data_q), .wrap_o(wrap_o), .disp_seg_o(disp_seg_o), .disp_an_o(disp_an_o)
   );

   always #5 clk = ~clk;

   assign len_i = {lenv[2], lenv[1], lenv[0]};

   always_comb begin
      rd_data = '0;
      for (int k = 0; k < NS; k++)
         rd_data[k*32 +: 32] = mem[k][rd_addr];
   end

   logic [7:0] HEX [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                            8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

   // model state
   logic [31:0] m_cnt;
   logic        m_prev;
   logic [2:0]  smp;
   int          m_sel;
   int          m_addr;
   logic [31:0] m_data;
   logic        m_wrap;
   logic [7:0]  m_seg, m_an;
   int          m_lastd;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // Advances the model by one clock edge from the inputs currently applied.
   task automatic mdl_edge();
      int b, eff, lim, n, d;
      logic at, mt, tk;
      logic [31:0] od;
      if (rst) begin
         m_cnt = 0; m_prev = 0; smp = 3'b000; m_sel = 0; m_addr = 0;
         m_data = 0; m_wrap = 0; m_seg = 8'hFF; m_an = 8'hFF; m_lastd = -1;
         return;
      end
      b = slow ? 4 : 2;
      at = m_cnt[b] & ~m_prev;
      m_prev = m_cnt[b];
      // a press is seen two edges after it was sampled, once per rising level
      mt = smp[1] & ~smp[2];
      smp = {smp[1:0], step_i};
      tk = run ? at : mt;
      eff = (int'(src_sel) < NS) ? int'(src_sel) : 0;
      od = m_data;
      if (!hold) m_data = mem[eff][m_addr];
      m_wrap = 0;
      if (eff != m_sel) m_addr = 0;
      else if (tk && !hold) begin
         lim = (lenv[eff] == 0) ? 64 : int'(lenv[eff]);
         n = m_addr + 1;
         if (n == lim || n == 64) begin m_addr = 0; m_wrap = 1; end
         else m_addr = n;
      end
      m_sel = eff;
      d = int'(m_cnt % 8);
      m_an = ~(8'd1 << d);
      m_seg = HEX[(od >> (4*d)) & 32'hF];
      if (hold && d == 7) m_seg[7] = 1'b0;
      m_lastd = d;
      m_cnt = m_cnt + 1;
   endtask

   task automatic cyc();
      @(posedge clk);
      mdl_edge();
      @(negedge clk);
      chk("rd_addr", 32'(rd_addr), 32'(m_addr));
      chk("data_q", data_q, m_data);
      chk("wrap_o", 32'(wrap_o), 32'(m_wrap));
      chk("seg", 32'(disp_seg_o), 32'(m_seg));
      chk("an", 32'(disp_an_o), 32'(m_an));
   endtask

   task automatic cycn(input int n);
      for (int i = 0; i < n; i++) cyc();
   endtask

   initial begin
      int wraps, a0;
      for (int k = 0; k < NS; k++)
         for (int a = 0; a < 64; a++)
            mem[k][a] = (k == 1) ? 32'(100 + a) : $urandom;
      mem[0][0] = 32'h1234ABCD;
      lenv[0] = 6'd0; lenv[1] = 6'd5; lenv[2] = 6'd9;
      rst = 1; slow = 0; run = 1; step_i = 0; hold = 0; src_sel = 0;
      m_lastd = -1;
      cycn(3);
      rst = 0;
      cycn(21);

      // reset mid-count
      rst = 1;
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk("rst_seg", 32'(disp_seg_o), 32'hFF);
         chk("rst_an", 32'(disp_an_o), 32'hFF);
         chk("rst_addr", 32'(rd_addr), 0);
         chk("rst_data", data_q, 0);
      end
      rst = 0;
      cyc();
      chk("first_an", 32'(disp_an_o), 32'hFE);
      chk("first_seg", 32'(disp_seg_o), 32'hC0);

      // auto stepping on channel 1, length 5
      src_sel = 1;
      wraps = 0;
      for (int i = 0; i < 48; i++) begin
         cyc();
         if (wrap_o) wraps++;
      end
      chk("auto_wraps", 32'(wraps), 1);

      // manual stepping: two long presses give two steps
      run = 0;
      src_sel = 2; cycn(2);
      src_sel = 1; cycn(2);
      for (int p = 0; p < 2; p++) begin
         step_i = 1; cycn(7);
         step_i = 0; cycn(7);
      end
      chk("man_steps", 32'(rd_addr), 2);
      step_i = 1; cyc(); step_i = 0; cycn(4);
      chk("man_addr3", 32'(rd_addr), 3);

      // channel change coinciding with a tick drops the tick
      step_i = 1; cycn(2);
      src_sel = 2; step_i = 0; cyc();
      chk("chg_addr", 32'(rd_addr), 0);
      cyc();
      chk("chg_data", data_q, mem[2][0]);
      src_sel = 3; cycn(2);
      chk("sel3_addr", 32'(rd_addr), 0);
      chk("sel3_data", data_q, mem[0][0]);

      // hold freezes address and data, dp lit on digit 7
      src_sel = 1; run = 1; cycn(20);
      hold = 1; cyc();
      a0 = m_addr;
      for (int i = 0; i < 40; i++) begin
         cyc();
         chk("hold_addr", 32'(rd_addr), 32'(a0));
         if (m_lastd == 7) chk("hold_dp", 32'(disp_seg_o[7]), 0);
      end
      hold = 0; cycn(24);

      // full-range wrap on channel 0 (length 0)
      run = 0; src_sel = 0; cycn(3);
      wraps = 0;
      for (int p = 0; p < 64; p++) begin
         step_i = 1; cyc(); if (wrap_o) wraps++;
         step_i = 0; cyc(); if (wrap_o) wraps++;
      end
      for (int i = 0; i < 4; i++) begin cyc(); if (wrap_o) wraps++; end
      chk("full_wraps", 32'(wraps), 1);
      chk("full_addr", 32'(rd_addr), 0);
      for (int i = 0; i < 10; i++) begin
         cyc();
         chk("hex_data", data_q, 32'h1234ABCD);
         if (m_lastd == 0) begin chk("d0_an", 32'(disp_an_o), 32'hFE); chk("d0_seg", 32'(disp_seg_o), 32'hA1); end
         if (m_lastd == 3) begin chk("d3_an", 32'(disp_an_o), 32'hF7); chk("d3_seg", 32'(disp_seg_o), 32'h88); end
         if (m_lastd == 7) begin chk("d7_an", 32'(disp_an_o), 32'h7F); chk("d7_seg", 32'(disp_seg_o), 32'hF9); end
      end

      // randomized traffic
      for (int i = 0; i < 2500; i++) begin
         if ($urandom_range(99) < 3) run = ~run;
         if ($urandom_range(99) < 3) slow = ~slow;
         if ($urandom_range(99) < 5) hold = ~hold;
         if ($urandom_range(99) < 4) src_sel = 2'($urandom_range(3));
         if ($urandom_range(99) < 20) step_i = ~step_i;
         if ($urandom_range(99) < 2) lenv[$urandom_range(NS-1)] = 6'($urandom_range(63));
         rst = ($urandom_range(499) == 0);
         cyc();
      end
      rst = 0;
      cycn(2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
